// File: rtl/mem_access_unit_pkg.sv
// Shared types, widths and funct3 decode for the load/store unit.
package mem_access_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

  // Unlisted codes (011/110/111) fall into the word bucket.
  function automatic lsu_size_e size_of(input logic [2:0] funct3);
    if (funct3[1])      return SZ_W;
    else if (funct3[0]) return SZ_H;
    else                return SZ_B;
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (size_of(funct3))
      SZ_H:    return off[0];
      SZ_W:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Byte-lane steering: store strobes/replicated data and load lane extraction with extension.
module mem_access_unit_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [DATA_W-1:0] wdata_lane,
  output logic [DATA_W-1:0] rdata_ext
);

  lsu_size_e         size;
  logic [1:0]        eff_off;
  logic [DATA_W-1:0] lane;
  logic              sext;

  // Halfwords drop addr[0] and words drop addr[1:0], forcing natural alignment.
  always_comb begin
    size       = size_of(funct3);
    sext       = ~funct3[2];
    eff_off    = 2'b00;
    wstrb      = '1;
    wdata_lane = wdata;
    case (size)
      SZ_B: begin
        eff_off    = off;
        wstrb      = STRB_W'(4'b0001 << off);
        wdata_lane = {4{wdata[7:0]}};
      end
      SZ_H: begin
        eff_off    = {off[1], 1'b0};
        wstrb      = STRB_W'(4'b0011 << eff_off);
        wdata_lane = {2{wdata[15:0]}};
      end
      default: begin
        eff_off    = 2'b00;
        wstrb      = '1;
        wdata_lane = wdata;
      end
    endcase
    lane = rdata >> {eff_off, 3'b000};
    case (size)
      SZ_B:    rdata_ext = {{24{sext & lane[7]}}, lane[7:0]};
      SZ_H:    rdata_ext = {{16{sext & lane[15]}}, lane[15:0]};
      default: rdata_ext = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one word-aligned data-memory request per accepted operation.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and return resp_err=1.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  lsu_state_e        state_q, state_d;
  mem_req_t          mreq_q, mreq_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic              idle;
  logic              access;
  logic              trap;
  logic [2:0]        al_funct3;
  logic [1:0]        al_off;
  logic [STRB_W-1:0] al_wstrb;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;

  assign idle   = (state_q == LSU_IDLE);
  assign access = req_load | req_store;

`ifdef MISALIGN_TRAP_EN
  assign trap = access & misaligned(req_funct3, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // One aligner: live request fields while idle, latched fields for the load return.
  assign al_funct3 = idle ? req_funct3 : funct3_q;
  assign al_off    = idle ? req_addr[1:0] : off_q;

  mem_access_unit_align u_align (
    .funct3     (al_funct3),
    .off        (al_off),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata)
  );

  always_comb begin
    state_d         = state_q;
    mreq_d          = mreq_q;
    funct3_d        = funct3_q;
    off_d           = off_q;
    req_ready_d     = req_ready_q;
    mem_req_valid_d = mem_req_valid_q;
    resp_valid_d    = resp_valid_q;
    resp_err_d      = resp_err_q;
    resp_rdata_d    = resp_rdata_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          funct3_d     = req_funct3;
          off_d        = req_addr[1:0];
          req_ready_d  = 1'b0;
          mreq_d.we    = req_store;
          mreq_d.addr  = {req_addr[ADDR_W-1:2], 2'b00};
          mreq_d.wdata = req_store ? al_wdata : '0;
          mreq_d.wstrb = req_store ? al_wstrb : '0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
          if (access && !trap) begin
            mem_req_valid_d = 1'b1;
            state_d         = LSU_REQ;
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = trap;
            state_d      = LSU_DONE;
          end
        end
      end
      LSU_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        if (mem_resp_valid) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = mreq_q.we ? '0 : al_rdata;
          state_d      = LSU_DONE;
        end
      end
      LSU_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= LSU_IDLE;
      mreq_q          <= '0;
      funct3_q        <= '0;
      off_q           <= '0;
      req_ready_q     <= 1'b1;
      mem_req_valid_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= '0;
    end else begin
      state_q         <= state_d;
      mreq_q          <= mreq_d;
      funct3_q        <= funct3_d;
      off_q           <= off_d;
      req_ready_q     <= req_ready_d;
      mem_req_valid_q <= mem_req_valid_d;
      resp_valid_q    <= resp_valid_d;
      resp_err_q      <= resp_err_d;
      resp_rdata_q    <= resp_rdata_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mreq_q.we;
  assign mem_addr      = mreq_q.addr;
  assign mem_wdata     = mreq_q.wdata;
  assign mem_wstrb     = mreq_q.wstrb;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;

endmodule
